gate_truth_sequencer: RTL and testbench

GATE_TRUTH_SEQUENCER -- requirements
Module: gate_truth_sequencer

---
 rtl/gate_truth_sequencer.sv | 174 +++++++++++++++++
 tb/tb_gate_truth_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: walks a 2-input gate through its four input
// vectors (00,01,10,11), holds each for SETTLE cycles, then checks the
// gate output z against the selected truth table and counts mismatches.
// Optional first-failure capture is built when GATE_SEQ_FAIL_CAPTURE_EN is defined.
module gate_truth_sequencer #(
    parameter int SETTLE = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       sample_valid
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    ,
    output logic       fail_valid,
    output logic [1:0] fail_vec
`endif
);

    localparam logic [7:0] SETTLE_L = 8'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] vec_q, vec_d;
    logic       x_q, x_d;
    logic       y_q, y_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic       expect_z;
    logic       mismatch;
    logic [1:0] vec_inc;

`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic       fvld_q, fvld_d;
    logic [1:0] fvec_q, fvec_d;
`endif

    // Truth table of the latched gate function for the current stimulus
    always_comb begin
        expect_z = 1'b0;
        case (sel_q)
            3'd0:    expect_z = x_q & y_q;
            3'd1:    expect_z = x_q | y_q;
            3'd2:    expect_z = ~(x_q & y_q);
            3'd3:    expect_z = ~(x_q | y_q);
            3'd4:    expect_z = x_q ^ y_q;
            3'd5:    expect_z = ~(x_q ^ y_q);
            3'd6:    expect_z = x_q;
            default: expect_z = ~x_q;
        endcase
    end

    assign mismatch = (z != expect_z);
    assign vec_inc  = vec_q + 2'd1;

    // Next-state logic; stimulus is loaded on the edge entering APPLY so the
    // gate sees it for the whole APPLY + SETTLE window before CHECK
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        fvld_d  = fvld_q;
        fvec_d  = fvec_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sel_d   = gate_sel;
                    err_d   = 3'd0;
                    vec_d   = 2'd0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                    fvld_d  = 1'b0;
                    fvec_d  = 2'd0;
`endif
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                cnt_d   = SETTLE_L;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q <= 8'd1) state_d = S_CHECK;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != 3'd4) err_d = err_q + 3'd1;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                    if (!fvld_q) begin
                        fvld_d = 1'b1;
                        fvec_d = vec_q;
                    end
`endif
                end
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_inc;
                    x_d     = vec_inc[1];
                    y_d     = vec_inc[0];
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset (reset wins over start)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            vec_q   <= 2'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 3'd0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            fvld_q  <= 1'b0;
            fvec_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vec_q   <= vec_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            fvld_q  <= fvld_d;
            fvec_q  <= fvec_d;
`endif
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign vec_idx      = vec_q;
    assign err_count    = err_q;
    assign busy         = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done         = (state_q == S_DONE);
    assign pass         = done && (err_q == 3'd0);
    assign sample_valid = (state_q == S_CHECK);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    assign fail_valid   = fvld_q;
    assign fail_vec     = fvec_q;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Scoreboard bench for gate_truth_sequencer: a modelled gate drives z, the
// expected per-vector and per-run results are queued at each accepted start
// and a negedge monitor pops and compares them.
module tb_gate_truth_sequencer;

    localparam int S = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, start_b = 1'b0;
    logic [2:0] gate_sel = 3'd0, gate_sel_b = 3'd0;
    logic       z, z_b, x, y, x_b, y_b;
    logic [1:0] vec_idx, vec_idx_b;
    logic       busy, done, pass, sample_valid;
    logic       busy_b, done_b, pass_b, sample_valid_b;
    logic [2:0] err_count, err_count_b;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic       fail_valid, fail_valid_b;
    logic [1:0] fail_vec, fail_vec_b;
`endif

    int gut = 0, gut_b = 7;   // function of the gate under test (8: tied 0, 9: tied 1)
    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int runs = 0;
    int strobes_b = 0;
    logic prev_done = 1'b0;

    function automatic logic gate_fn(int f, logic a, logic b);
        case (f)
            0: return a & b;
            1: return a | b;
            2: return !(a & b);
            3: return !(a | b);
            4: return a ^ b;
            5: return a == b;
            6: return a;
            7: return !a;
            8: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign z   = gate_fn(gut, x, y);
    assign z_b = gate_fn(gut_b, x_b, y_b);

    gate_truth_sequencer #(.SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .z(z),
        .x(x), .y(y), .vec_idx(vec_idx), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .sample_valid(sample_valid)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        , .fail_valid(fail_valid), .fail_vec(fail_vec)
`endif
    );

    gate_truth_sequencer #(.SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .gate_sel(gate_sel_b), .z(z_b),
        .x(x_b), .y(y_b), .vec_idx(vec_idx_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_count_b), .sample_valid(sample_valid_b)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        , .fail_valid(fail_valid_b), .fail_vec(fail_vec_b)
`endif
    );

    typedef struct { int vec; int err_before; } vexp_t;
    typedef struct { int err; int ok; int fv; int fvec; int t0; } rexp_t;
    vexp_t vq[$];
    rexp_t rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-vector checks on each strobe, per-run checks on done rise
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (sample_valid) begin
                if (vq.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    vexp_t e;
                    e = vq.pop_front();
                    check("vec_idx", int'(vec_idx), e.vec);
                    check("x", int'(x), (e.vec >> 1) & 1);
                    check("y", int'(y), e.vec & 1);
                    check("err_before", int'(err_count), e.err_before);
                    check("busy_in_check", int'(busy), 1);
                end
            end
            if (done && !prev_done) begin
                if (rq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    check("done_latency", cyc - r.t0, 4 * (S + 2));
                    check("err_count", int'(err_count), r.err);
                    check("pass", int'(pass), r.ok);
                    check("busy_at_done", int'(busy), 0);
                    check("vectors_left", vq.size(), 0);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                    check("fail_valid", int'(fail_valid), r.fv);
                    if (r.fv != 0) check("fail_vec", int'(fail_vec), r.fvec);
`endif
                end
                runs <= runs + 1;
            end
            prev_done <= done;
        end
        if (sample_valid_b) strobes_b <= strobes_b + 1;
    end

    // Issue an accepted start and queue what the run must produce
    task automatic issue(int sel, int g);
        rexp_t r;
        int err;
        @(negedge clk);
        gut = g;
        gate_sel = 3'(sel);
        start = 1'b1;
        err = 0;
        r.fv = 0;
        r.fvec = 0;
        for (int v = 0; v < 4; v++) begin
            logic a, b;
            a = (v >> 1) & 1;
            b = v & 1;
            vq.push_back('{vec: v, err_before: err});
            if (gate_fn(g, a, b) != gate_fn(sel, a, b)) begin
                if (r.fv == 0) begin
                    r.fv = 1;
                    r.fvec = v;
                end
                if (err < 4) err++;
            end
        end
        r.err = err;
        r.ok = (err == 0) ? 1 : 0;
        r.t0 = cyc + 1;
        rq.push_back(r);
        @(negedge clk);
        start = 1'b0;
        gate_sel = 3'($urandom_range(0, 7));   // must be ignored after latch
    endtask

    task automatic wait_done();
        int c0, k;
        c0 = runs;
        k = 0;
        while (runs == c0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("run_completed", runs - c0, 1);
        @(negedge clk);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_xyv"}, int'({x, y, vec_idx}), 0);
        check({tag, "_sv"}, int'(sample_valid), 0);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        check({tag, "_fail"}, int'({fail_valid, fail_vec}), 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Correct NAND; sequence, latency, pass
        issue(2, 2);
        wait_done();
        // z stuck at 0 with NAND expected
        issue(2, 8);
        wait_done();
        // XOR gate under test, AND expected
        issue(0, 4);
        wait_done();
        // every vector wrong: count tops out at 4
        issue(6, 7);
        wait_done();
        repeat (3) @(negedge clk);
        check("done_held", int'(done), 1);
        check("err_held", int'(err_count), 4);
        check("xy_held", int'({x, y}), 3);

        // Start re-pulsed at cycle 10 of the run must be ignored
        issue(1, 1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset during SETTLE of vector 2, then a clean run
        issue(3, 3);
        repeat (19) @(negedge clk);
        check("mid_vec2", int'(vec_idx), 2);
        rst = 1'b1;
        vq.delete();
        rq.delete();
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        issue(3, 3);
        wait_done();

        // Reset beats a simultaneous start
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_all_zero("rst_vs_start");

        // Randomized runs
        for (int i = 0; i < 10; i++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 9));
            wait_done();
        end

        // SETTLE=1 instance with a NOT gate
        begin
            int t0, k;
            @(negedge clk);
            gate_sel_b = 3'd7;
            gut_b = 7;
            start_b = 1'b1;
            t0 = cyc + 1;
            strobes_b = 0;
            @(negedge clk);
            start_b = 1'b0;
            k = 0;
            while (!done_b && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("b_latency", cyc - t0, 12);
            check("b_strobes", strobes_b, 4);
            check("b_pass", int'(pass_b), 1);
            check("b_err", int'(err_count_b), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
